// File: rtl/sdr_capture_master.sv
// sdr_capture_master: Avalon-MM write master that fills a contiguous RAM word
// region with 32-bit I/Q samples on command, reporting progress, completion and drops.
module sdr_capture_master #(
  parameter int ADDR_W    = 12,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   length,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W:0]   ONE  = 1;

  state_t          state;
  logic [ADDR_W:0] length_q;
  logic [ADDR_W:0] accepted;
  logic            pending;
  logic            abort_q;

  logic            in_capture;
  logic            abort_seen;
  logic            room;
  logic            accept;
  logic            complete;
  logic            drop;
  logic            last_write;

  // Handshakes: a sample transfers when s_valid & s_ready are both high; the
  // source cannot stall, so a valid sample seen with s_ready low is lost.
  // A write transfers when m_write is high and m_waitrequest is low; until then
  // address, data and m_write are held.
  assign in_capture = (state == CAPTURE);
  assign abort_seen = in_capture & (abort | abort_q);
  assign room       = (accepted < length_q);
  assign complete   = pending & ~m_waitrequest;
  assign s_ready    = in_capture & ~abort_seen & room & (~pending | ~m_waitrequest);
  assign accept     = s_valid & s_ready;
  assign drop       = in_capture & s_valid & ~s_ready & room;
  assign last_write = complete & ((count + ONE) == length_q);

  assign m_write      = pending;
  assign m_chipselect = pending;
  assign m_byteenable = 4'hF;
  assign busy         = in_capture;
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      length_q    <= '0;
      accepted    <= '0;
      count       <= '0;
      pending     <= 1'b0;
      abort_q     <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
    end else begin
      case (state)
        IDLE, DONE_ST: begin
          if (start) begin
            length_q <= length;
            accepted <= '0;
            count    <= '0;
            overflow <= 1'b0;
            abort_q  <= 1'b0;
            pending  <= 1'b0;
            if (length == '0) begin
              state <= DONE_ST;
              done  <= 1'b1;
            end else begin
              state <= CAPTURE;
              done  <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (drop)  overflow <= 1'b1;
          if (abort) abort_q  <= 1'b1;
          if (accept) begin
            m_writedata <= s_data;
            m_address   <= BASE + accepted[ADDR_W-1:0];
            accepted    <= accepted + ONE;
            pending     <= 1'b1;
          end else if (complete) begin
            pending <= 1'b0;
          end
          if (complete) count <= count + ONE;
          // An abort only retires once the holding register has drained.
          if (last_write) begin
            state   <= DONE_ST;
            done    <= 1'b1;
            abort_q <= 1'b0;
          end else if (abort_seen && (!pending || complete)) begin
            state   <= IDLE;
            abort_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_capture_master.sv
// Bench for sdr_capture_master: two instances (base 0 and base 4094) share stimulus
// and are compared every cycle against a queue-based behavioural model.
module tb_sdr_capture_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, s_valid, m_waitrequest;
  logic [12:0] length;
  logic [31:0] s_data;

  logic        s_ready_0, m_chipselect_0, m_write_0, busy_0, done_0, overflow_0;
  logic [11:0] m_address_0;
  logic [31:0] m_writedata_0;
  logic [3:0]  m_byteenable_0;
  logic [12:0] count_0;
  logic [1:0]  fsm_state_0;
  logic        s_ready_1, m_chipselect_1, m_write_1, busy_1, done_1, overflow_1;
  logic [11:0] m_address_1;
  logic [31:0] m_writedata_1;
  logic [3:0]  m_byteenable_1;
  logic [12:0] count_1;
  logic [1:0]  fsm_state_1;

  sdr_capture_master #(.ADDR_W(12), .BASE_WORD(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_0),
    .m_address(m_address_0), .m_chipselect(m_chipselect_0), .m_write(m_write_0),
    .m_writedata(m_writedata_0), .m_byteenable(m_byteenable_0),
    .m_waitrequest(m_waitrequest), .busy(busy_0), .done(done_0),
    .overflow(overflow_0), .count(count_0), .fsm_state(fsm_state_0));

  sdr_capture_master #(.ADDR_W(12), .BASE_WORD(4094)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_1),
    .m_address(m_address_1), .m_chipselect(m_chipselect_1), .m_write(m_write_1),
    .m_writedata(m_writedata_1), .m_byteenable(m_byteenable_1),
    .m_waitrequest(m_waitrequest), .busy(busy_1), .done(done_1),
    .overflow(overflow_1), .count(count_1), .fsm_state(fsm_state_1));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 = IDLE, 1 = CAPTURE, 2 = DONE. The outstanding write is a queue of
  // sample indices plus data; it never holds more than one entry.
  int          m_mode, m_len, m_acc, m_cnt;
  bit          m_ovf, m_done, m_abort;
  int          pq_idx[$];
  logic [31:0] pq_data[$];
  bit          exp_ready, aborting, fin;

  // bench-side RAM slave observations
  logic [31:0] ram0 [4096];
  int          wcnt [4096];
  int          n_writes0;
  int          addr1_log[$];

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_acc = 0; m_cnt = 0;
    m_ovf = 0; m_done = 0; m_abort = 0;
    pq_idx.delete(); pq_data.delete();
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      model_reset();
      chk("rst_m_write", {m_write_1, m_write_0}, 0);
      chk("rst_busy", {busy_1, busy_0}, 0);
      chk("rst_done", {done_1, done_0}, 0);
      chk("rst_count", {count_1, count_0}, 0);
    end else begin
      aborting  = (m_mode == 1) && (abort || m_abort);
      exp_ready = (m_mode == 1) && !aborting && (m_acc < m_len) &&
                  (pq_idx.size() == 0 || !m_waitrequest);
      chk("s_ready", {s_ready_1, s_ready_0}, {62'd0, exp_ready, exp_ready});
      chk("m_write", {m_chipselect_1, m_write_1, m_chipselect_0, m_write_0},
          (pq_idx.size() != 0) ? 64'hF : 64'h0);
      chk("byteenable", {m_byteenable_1, m_byteenable_0}, 64'hFF);
      chk("busy", {busy_1, busy_0}, (m_mode == 1) ? 64'h3 : 64'h0);
      chk("done", {done_1, done_0}, m_done ? 64'h3 : 64'h0);
      chk("overflow", {overflow_1, overflow_0}, m_ovf ? 64'h3 : 64'h0);
      chk("count0", count_0, 64'(m_cnt));
      chk("count1", count_1, 64'(m_cnt));
      if (pq_idx.size() != 0) begin
        chk("address0", m_address_0, 64'(pq_idx[0] % 4096));
        chk("address1", m_address_1, 64'((4094 + pq_idx[0]) % 4096));
        chk("writedata0", m_writedata_0, 64'(pq_data[0]));
        chk("writedata1", m_writedata_1, 64'(pq_data[0]));
      end
      // slave side: log whatever the DUTs actually deliver
      if (m_write_0 && !m_waitrequest) begin
        ram0[m_address_0] = m_writedata_0;
        wcnt[m_address_0]++;
        n_writes0++;
      end
      if (m_write_1 && !m_waitrequest) addr1_log.push_back(int'(m_address_1));
      // advance to the state seen after the coming rising edge
      if (m_mode != 1) begin
        if (start) begin
          m_len = int'(length); m_acc = 0; m_cnt = 0;
          m_ovf = 0; m_abort = 0;
          m_done = (length == 0);
          m_mode = (length == 0) ? 2 : 1;
        end
      end else begin
        fin = 0;
        if (pq_idx.size() != 0 && !m_waitrequest) begin
          void'(pq_idx.pop_front());
          void'(pq_data.pop_front());
          m_cnt++;
          fin = (m_cnt == m_len);
        end
        if (s_valid && exp_ready) begin
          pq_idx.push_back(m_acc);
          pq_data.push_back(s_data);
          m_acc++;
        end else if (s_valid && m_acc < m_len) begin
          m_ovf = 1;
        end
        if (abort) m_abort = 1;
        if (fin) begin
          m_mode = 2;
          m_done = 1;
        end else if (m_abort && pq_idx.size() == 0) begin
          m_mode = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; s_valid = 0; m_waitrequest = 0; s_data = '0;
  endtask

  // ---------------- stimulus ----------------
  int done_at;
  int budget;
  int bad;
  logic [31:0] exp_w [4];

  initial begin
    idle_inputs();
    length  = '0;
    reset_n = 1'b1;
    n_writes0 = 0;
    for (int a = 0; a < 4096; a++) begin
      ram0[a] = 32'hDEAD_BEEF;
      wcnt[a] = 0;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rst_address", m_address_0, 0);
    chk("rst_writedata", m_writedata_0, 0);
    chk("rst_byteenable", m_byteenable_0, 4'hF);
    chk("rst_overflow", overflow_0, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // 8 words, continuous valid; a second start mid-capture must be ignored
    done_at = -1;
    for (int k = 0; k < 14; k++) begin
      start   = (k == 0) || (k == 4);
      length  = (k == 4) ? 13'd2 : 13'd8;
      s_valid = 1;
      s_data  = 32'h0001_0000 + 32'(k) - 32'd1;
      tick();
      if (done_0 && done_at < 0) done_at = k + 1;
    end
    idle_inputs();
    chk("len8_done_cycle", 64'(done_at), 10);
    chk("len8_count", count_0, 8);
    chk("len8_overflow", overflow_0, 0);
    for (int i = 0; i < 8; i++) chk("len8_ram", ram0[i], 32'h0001_0000 + 32'(i));

    // 4 words with a 3-cycle stall on the second write
    addr1_log.delete();
    n_writes0 = 0;
    for (int k = 0; k < 12; k++) begin
      start         = (k == 0);
      length        = 13'd4;
      s_valid       = 1;
      s_data        = 32'hA000_0000 + 32'(k);
      m_waitrequest = (k >= 3 && k <= 5);
      tick();
    end
    idle_inputs();
    exp_w[0] = 32'hA000_0001; exp_w[1] = 32'hA000_0002;
    exp_w[2] = 32'hA000_0006; exp_w[3] = 32'hA000_0007;
    chk("stall_overflow", overflow_0, 1);
    chk("stall_done", done_0, 1);
    chk("stall_writes", 64'(n_writes0), 4);
    for (int i = 0; i < 4; i++) chk("stall_ram", ram0[i], exp_w[i]);
    chk("wrap_log_size", 64'(addr1_log.size()), 4);
    if (addr1_log.size() == 4) begin
      chk("wrap_addr0", 64'(addr1_log[0]), 4094);
      chk("wrap_addr1", 64'(addr1_log[1]), 4095);
      chk("wrap_addr2", 64'(addr1_log[2]), 0);
      chk("wrap_addr3", 64'(addr1_log[3]), 1);
    end

    // restart after DONE clears status; then abort with a stalled write
    start = 1; length = 13'd8;
    tick();
    start = 0;
    chk("restart_done", done_0, 0);
    chk("restart_overflow", overflow_0, 0);
    chk("restart_count", count_0, 0);
    chk("restart_busy", busy_0, 1);
    for (int k = 1; k < 10; k++) begin
      s_valid       = (k <= 3);
      s_data        = 32'hB000_0000 + 32'(k);
      abort         = (k == 4);
      m_waitrequest = (k == 4 || k == 5);
      tick();
    end
    idle_inputs();
    chk("abort_count", count_0, 3);
    chk("abort_done", done_0, 0);
    chk("abort_busy", busy_0, 0);
    chk("abort_ram", ram0[2], 32'hB000_0003);

    // zero-length capture
    n_writes0 = 0;
    start = 1; length = 13'd0;
    tick();
    start = 0;
    chk("len0_done", done_0, 1);
    chk("len0_busy", busy_0, 0);
    tick(); tick();
    chk("len0_writes", 64'(n_writes0), 0);

    // asynchronous reset with a write in flight
    start = 1; length = 13'd8; s_valid = 1;
    tick();
    start = 0;
    tick(); tick();
    chk("pre_reset_m_write", m_write_0, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_m_write", {m_write_1, m_write_0}, 0);
    chk("async_busy", busy_0, 0);
    chk("async_done", done_0, 0);
    idle_inputs();
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // randomized episodes
    for (int e = 0; e < 40; e++) begin
      start = 1; length = 13'($urandom_range(0, 24));
      tick();
      start = 0;
      budget = 0;
      while (m_mode == 1 && budget < 300) begin
        s_valid       = ($urandom_range(0, 3) != 0);
        s_data        = $urandom;
        m_waitrequest = ($urandom_range(0, 3) == 0);
        abort         = ($urandom_range(0, 40) == 0);
        start         = ($urandom_range(0, 30) == 0);
        length        = 13'($urandom_range(0, 24));
        tick();
        budget++;
      end
      chk("rand_timeout", 64'(budget < 300), 1);
      idle_inputs();
      tick();
    end

    // full-region capture: every word written exactly once
    for (int a = 0; a < 4096; a++) wcnt[a] = 0;
    start = 1; length = 13'd4096;
    tick();
    start = 0;
    budget = 0;
    while (m_mode == 1 && budget < 5000) begin
      s_valid = 1;
      s_data  = $urandom;
      tick();
      budget++;
    end
    idle_inputs();
    chk("full_timeout", 64'(budget < 5000), 1);
    chk("full_count", count_0, 4096);
    bad = 0;
    for (int a = 0; a < 4096; a++) if (wcnt[a] != 1) bad++;
    chk("full_cover", 64'(bad), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
